// File: rtl/adc_spi_rx_multi_if.sv
// Bus bundle between the serial ADC front end and its environment.
// The master side generates cs/sclk and publishes the captured words.
interface adc_spi_rx_multi_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DATA_W = 12
);
    logic                     EN;
    logic [N_CH-1:0]          dato_ser;
    logic                     cs;
    logic                     sclk;
    logic                     busy;
    logic                     rx_done;
    logic [N_CH*DATA_W-1:0]   data_out;
    logic [N_CH-1:0]          frame_err;

    modport master (
        input  EN, dato_ser,
        output cs, sclk, busy, rx_done, data_out, frame_err
    );

    modport slave (
        output EN, dato_ser,
        input  cs, sclk, busy, rx_done, data_out, frame_err
    );
endinterface

// File: rtl/adc_spi_rx_multi.sv
// Multi-lane serial ADC receiver: drives cs/sclk at a fixed conversion rate and
// captures N_CH MSB-first frames in parallel, flagging non-zero pad bits.
module adc_spi_rx_multi #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FRAME_W     = 16,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned SCLK_DIV    = 2,
    parameter int unsigned CONV_PERIOD = 80,
    parameter int unsigned CS_HIGH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    adc_spi_rx_multi_if.master  bus
);
    localparam int unsigned DIV_W = $clog2(SCLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(FRAME_W + 1);
    localparam int unsigned PER_W = $clog2(CONV_PERIOD + 1);
    localparam int unsigned HI_W  = $clog2(CS_HIGH + 2);
    localparam logic [FRAME_W-1:0] PAD_MASK = {FRAME_W{1'b1}} << DATA_W;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

    state_t                   state_q;
    logic                     cs_q, sclk_q, busy_q, rx_done_q;
    logic [N_CH*DATA_W-1:0]   data_out_q;
    logic [N_CH-1:0]          frame_err_q;
    logic [DIV_W-1:0]         div_cnt_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [PER_W-1:0]         per_cnt_q;
    logic [HI_W-1:0]          hi_cnt_q;
    logic [FRAME_W-1:0]       sr_q [N_CH];

    logic period_end_c;
    logic start_c;

    // A new frame may begin immediately from IDLE, or from GAP at the period boundary.
    always_comb begin
        period_end_c = (per_cnt_q == PER_W'(CONV_PERIOD - 1)) && (hi_cnt_q >= HI_W'(CS_HIGH));
        start_c      = bus.EN && ((state_q == IDLE) || ((state_q == GAP) && period_end_c));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b1;
            busy_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            data_out_q  <= '0;
            frame_err_q <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            for (int k = 0; k < int'(N_CH); k++) sr_q[k] <= '0;
        end else begin
            rx_done_q <= 1'b0;
            if (per_cnt_q != PER_W'(CONV_PERIOD - 1)) per_cnt_q <= per_cnt_q + PER_W'(1);
            if (cs_q && (hi_cnt_q < HI_W'(CS_HIGH))) hi_cnt_q <= hi_cnt_q + HI_W'(1);

            case (state_q)
                IDLE: per_cnt_q <= '0;
                SHIFT: begin
                    if (div_cnt_q == DIV_W'(SCLK_DIV - 1)) begin
                        div_cnt_q <= '0;
                        if (!sclk_q) begin
                            // Rising sclk edge: capture every lane.
                            sclk_q <= 1'b1;
                            for (int k = 0; k < int'(N_CH); k++)
                                sr_q[k] <= (sr_q[k] << 1) | FRAME_W'(bus.dato_ser[k]);
                        end else if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
                            state_q  <= DONE;
                            cs_q     <= 1'b1;
                            busy_q   <= 1'b0;
                            hi_cnt_q <= HI_W'(1);
                        end else begin
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                DONE: begin
                    for (int k = 0; k < int'(N_CH); k++) begin
                        data_out_q[k*DATA_W +: DATA_W] <= sr_q[k][DATA_W-1:0];
                        frame_err_q[k]                 <= |(sr_q[k] & PAD_MASK);
                    end
                    rx_done_q <= 1'b1;
                    state_q   <= GAP;
                end
                GAP: if (period_end_c && !bus.EN) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (start_c) begin
                state_q   <= SHIFT;
                cs_q      <= 1'b0;
                sclk_q    <= 1'b0;
                busy_q    <= 1'b1;
                div_cnt_q <= '0;
                bit_cnt_q <= '0;
                per_cnt_q <= '0;
            end
        end
    end

    assign bus.cs        = cs_q;
    assign bus.sclk      = sclk_q;
    assign bus.busy      = busy_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.data_out  = data_out_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_adc_spi_rx_multi.sv
// Directed + randomized bench for adc_spi_rx_multi with a behavioural ADC model
// and frame-level reference expectations.
module tb_adc_spi_rx_multi;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned N_CH    = 2;

    logic clk;
    logic rst;

    adc_spi_rx_multi_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    adc_spi_rx_multi #(
        .DATA_W(DATA_W), .FRAME_W(FRAME_W), .N_CH(N_CH),
        .SCLK_DIV(2), .CONV_PERIOD(80), .CS_HIGH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [FRAME_W-1:0] tx_word [N_CH];
    logic [FRAME_W-1:0] cur_word [N_CH];
    int adc_idx = -1;

    int cyc = 0, nfall = 0, last_fall = -1000, last_rise = 0;
    int fall_gap = 0, high_len = 0, rx_cnt = 0, last_rx = 0, sclk_edges = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event monitor: cs edges, sclk activity and rx_done strobes.
    initial begin
        logic pcs, psc;
        pcs = 1'b1;
        psc = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pcs && !bus.cs) begin
                fall_gap  = cyc - last_fall;
                high_len  = cyc - last_rise;
                last_fall = cyc;
                nfall++;
            end
            if (!pcs && bus.cs) last_rise = cyc;
            if (psc !== bus.sclk) sclk_edges++;
            if (bus.rx_done === 1'b1) begin
                rx_cnt++;
                last_rx = cyc;
            end
            pcs = bus.cs;
            psc = bus.sclk;
        end
    end

    // ADC model: latch the words at cs fall, present MSB first, advance on sclk fall.
    initial begin
        logic pcs, psc;
        pcs = 1'b1;
        psc = 1'b1;
        bus.dato_ser = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pcs && !bus.cs) begin
                for (int k = 0; k < int'(N_CH); k++) cur_word[k] = tx_word[k];
                adc_idx = FRAME_W - 1;
            end else if (psc && !bus.sclk && !bus.cs && adc_idx > 0) begin
                adc_idx--;
            end
            if (adc_idx >= 0)
                for (int k = 0; k < int'(N_CH); k++) bus.dato_ser[k] = cur_word[k][adc_idx];
            pcs = bus.cs;
            psc = bus.sclk;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CH*DATA_W-1:0] exp_data();
        logic [N_CH*DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(N_CH); k++)
            r[k*DATA_W +: DATA_W] = DATA_W'(tx_word[k] % (1 << DATA_W));
        return r;
    endfunction

    function automatic logic [N_CH-1:0] exp_err();
        logic [N_CH-1:0] r;
        for (int k = 0; k < int'(N_CH); k++) r[k] = ((tx_word[k] >> DATA_W) != 0);
        return r;
    endfunction

    task automatic wait_rx(input string tag);
        int  n0;
        bit  ok;
        n0 = rx_cnt;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (rx_cnt != n0);
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_fall(input string tag);
        int  n0;
        bit  ok;
        n0 = nfall;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk);
            #2;
            ok = (nfall != n0);
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_data"}, 64'(bus.data_out), 64'(exp_data()));
        chk({tag, "_err"}, 64'(bus.frame_err), 64'(exp_err()));
        chk({tag, "_lat"}, 64'(last_rx - last_fall), 64'd65);
    endtask

    initial begin
        int e0, f0, r0;
        logic [FRAME_W-1:0] corner [3];
        corner[0] = 16'h0000;
        corner[1] = 16'h0FFF;
        corner[2] = 16'h0800;
        for (int k = 0; k < int'(N_CH); k++) tx_word[k] = '0;

        // Reset and idle
        rst    = 1'b0;
        bus.EN = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_cs", 64'(bus.cs), 64'd1);
        chk("rst_sclk", 64'(bus.sclk), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rx", 64'(bus.rx_done), 64'd0);
        chk("rst_data", 64'(bus.data_out), 64'd0);
        chk("rst_err", 64'(bus.frame_err), 64'd0);
        rst = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        chk("idle_cs", 64'(bus.cs), 64'd1);
        chk("idle_sclk_edges", 64'(sclk_edges), 64'd0);
        chk("idle_rx_cnt", 64'(rx_cnt), 64'd0);
        chk("idle_data", 64'(bus.data_out), 64'd0);

        // Single known frame
        tx_word[0] = 16'h0ABC;
        tx_word[1] = 16'h0555;
        bus.EN = 1'b1;
        wait_rx("single_wait");
        chk_frame("single");
        chk("single_val", 64'(bus.data_out), 64'h555ABC);
        chk("single_cs_low", 64'(last_rise - last_fall), 64'd64);
        @(posedge clk);
        #2;
        chk("single_pulse", 64'(bus.rx_done), 64'd0);
        chk("single_hold", 64'(bus.data_out), 64'h555ABC);

        // Continuous randomized stream
        for (int i = 0; i < 100; i++) begin
            tx_word[0] = (i < 3) ? corner[i] : FRAME_W'($urandom_range(0, 4095));
            tx_word[1] = ($urandom_range(0, 3) == 0) ? FRAME_W'($urandom())
                                                     : FRAME_W'($urandom_range(0, 4095));
            wait_rx("stream_wait");
            chk_frame("stream");
            chk("stream_period", 64'(fall_gap), 64'd80);
            chk("stream_cs_high", 64'(high_len), 64'd16);
        end

        // Pad error, then a clean frame clears it
        tx_word[0] = 16'h0321;
        tx_word[1] = 16'h8123;
        wait_rx("pad_wait");
        chk_frame("pad");
        chk("pad_ch1", 64'(bus.data_out[2*DATA_W-1:DATA_W]), 64'h123);
        chk("pad_flag", 64'(bus.frame_err), 64'b10);
        tx_word[1] = 16'h0123;
        wait_rx("clean_wait");
        chk("clean_flag", 64'(bus.frame_err), 64'b00);

        // EN drop mid-frame
        tx_word[0] = FRAME_W'($urandom_range(0, 4095));
        tx_word[1] = FRAME_W'($urandom_range(0, 4095));
        wait_fall("endrop_fall");
        repeat (20) @(posedge clk);
        #2;
        bus.EN = 1'b0;
        wait_rx("endrop_wait");
        chk_frame("endrop");
        e0 = sclk_edges;
        f0 = nfall;
        repeat (150) @(posedge clk);
        #2;
        chk("endrop_sclk", 64'(sclk_edges), 64'(e0));
        chk("endrop_nofall", 64'(nfall), 64'(f0));
        chk("endrop_cs", 64'(bus.cs), 64'd1);

        // Reset mid-frame
        tx_word[0] = FRAME_W'($urandom_range(0, 4095));
        tx_word[1] = FRAME_W'($urandom_range(0, 4095));
        bus.EN = 1'b1;
        wait_fall("rstmid_fall");
        r0 = rx_cnt;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rstmid_cs", 64'(bus.cs), 64'd1);
        chk("rstmid_sclk", 64'(bus.sclk), 64'd1);
        chk("rstmid_busy", 64'(bus.busy), 64'd0);
        chk("rstmid_data", 64'(bus.data_out), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("rstmid_norx", 64'(rx_cnt), 64'(r0));
        tx_word[0] = FRAME_W'($urandom_range(0, 4095));
        tx_word[1] = FRAME_W'($urandom_range(0, 4095));
        rst = 1'b1;
        wait_rx("rstmid_wait");
        chk_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
